seq_mult_ctrl: RTL and testbench

Multi-cycle controller that sequences a radix-2 shift-add multiply on the 32-bit integer datapath, producing the 64-bit HI/LO result for MULT/MULTU. It sits beside the single-cycle ALU units in the execute stage. The pipeline issues the operation with a start pulse and stalls on busy until done.

---
 rtl/seq_mult_ctrl.sv | 116 +++++++++++
 tb/tb_seq_mult_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl
// Multi-cycle radix-2 shift-add multiplier controller for MULT/MULTU.
// Operands are captured on start; the multiply runs WIDTH iterations, then a
// sign-fixup cycle writes the 2*WIDTH-bit product to hi/lo and pulses done.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      operation request, sampled only in IDLE
//   signed_op  1 = two's complement multiply, 0 = unsigned (captured with start)
//   a, b       multiplicand / multiplier (captured with start)
//   busy       high while an operation is in flight (RUN or FIX)
//   done       one-cycle pulse; hi/lo valid from this cycle
//   hi, lo     upper / lower product halves, held until the next done
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; done pulses here for one cycle after FIX
// RUN   | one shift-add iteration per clock, WIDTH iterations in total
// FIX   | apply sign to the magnitude product, load hi/lo, raise done

module seq_mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_neg;

  // The most negative input maps to itself, which is the correct unsigned
  // magnitude, so no extra bit is needed.
  assign a_mag = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // Carry out of the upper-half add is kept and shifted back in as the new MSB.
  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_neg = ~acc + (2*WIDTH)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          {hi, lo} <= neg ? acc_neg : acc;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl
// Scoreboard bench: expected products are pushed when an operation is issued
// and popped when done is observed.

module tb_seq_mult_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [2*W-1:0] sb_q[$];

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [2*W-1:0] model(input logic sop, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    longint         sp;
    logic [2*W-1:0] up;
    if (sop) begin
      sp = longint'($signed(x)) * longint'($signed(y));
      return sp;
    end
    up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return up;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after the start edge.
  task automatic start_op(input logic sop, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; signed_op = sop; a = x; b = y;
    sb_q.push_back(model(sop, x, y));
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; signed_op = $urandom_range(0, 1);
  endtask

  // Waits (bounded) for done. lat counts cycles after the start edge, busy_n the
  // cycles busy was seen high, held=0 if hi/lo moved before done.
  task automatic wait_done(output int lat, output int busy_n, output bit held);
    logic [2*W-1:0] snap;
    snap = {hi, lo};
    lat = 1; busy_n = 0; held = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_n++;
      if ({hi, lo} !== snap) held = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string name);
    logic [2*W-1:0] exp;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: done seen with empty scoreboard, got %h_%h", name, hi, lo);
    end else begin
      exp = sb_q.pop_front();
      if ({hi, lo} !== exp) begin
        n_fail++;
        $display("FAIL %s: got hi:lo=%h_%h expected %h_%h", name, hi, lo,
                 exp[2*W-1:W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_rst: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_unsigned();
    int lat, bn; bit held;
    start_op(1'b0, 32'd3, 32'd5);
    wait_done(lat, bn, held);
    n_checks++;
    if (lat !== 34) begin n_fail++; $display("FAIL latency_3x5: got %0d expected 34", lat); end
    n_checks++;
    if (bn !== 33) begin n_fail++; $display("FAIL busy_cycles_3x5: got %0d expected 33", bn); end
    n_checks++;
    if (!held) begin n_fail++; $display("FAIL hold_during_run: got changed expected held"); end
    check_result("mulu_3x5");
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got done=%b expected 0", done); end
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bn, held);
    check_result("mulu_max");
    @(negedge clk);
  endtask

  task automatic test_signed();
    int lat, bn; bit held;
    logic [W-1:0] va[3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] vb[3] = '{32'd7,         32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      start_op(1'b1, va[i], vb[i]);
      wait_done(lat, bn, held);
      check_result($sformatf("mult_%0d", i));
      @(negedge clk);
    end
    // Same negative bit pattern treated as unsigned must not be sign-fixed.
    start_op(1'b0, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat, bn, held);
    check_result("multu_neg_pattern");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bn, d0; bit held;
    d0 = done_cnt;
    start_op(1'b0, 32'd3, 32'd5);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 10) begin start = 1'b1; a = 32'd9; b = 32'd9; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (lat !== 34) begin n_fail++; $display("FAIL latency_ignored_start: got %0d expected 34", lat); end
    check_result("ignored_start_3x5");
    // New op issued in the done cycle.
    start_op(1'b0, 32'd2, 32'd4);
    n_checks++;
    if ({done, busy, hi, lo} !== {2'b01, 32'd0, 32'd15}) begin
      n_fail++;
      $display("FAIL b2b_accept: got done=%b busy=%b lo=%h expected 0 1 0000000f", done, busy, lo);
    end
    wait_done(lat, bn, held);
    n_checks++;
    if (!held) begin n_fail++; $display("FAIL b2b_hold: got changed expected held"); end
    n_checks++;
    if (lat !== 34) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    check_result("b2b_2x4");
    @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL done_count: got %0d expected 2", done_cnt - d0); end
  endtask

  task automatic test_abort();
    int lat, bn, d0; bit held;
    logic [2*W-1:0] junk;
    start_op(1'b0, 32'd11, 32'd13);
    for (int i = 1; i < 20; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL abort_async: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    junk = sb_q.pop_front();
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 40; i++) @(negedge clk);
    n_checks++;
    if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0); end
    start_op(1'b0, 32'd6, 32'd7);
    wait_done(lat, bn, held);
    check_result("after_abort_6x7");
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat, bn; bit held;
    start_op(1'b0, 32'd0, 32'h1234_5678);
    wait_done(lat, bn, held);
    n_checks++;
    if (lat !== 34) begin n_fail++; $display("FAIL zero_latency: got %0d expected 34", lat); end
    check_result("zero_operand");
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bn; bit held;
    for (int i = 0; i < 6; i++) begin
      start_op(1'($urandom_range(0, 1)), $urandom, $urandom);
      wait_done(lat, bn, held);
      check_result($sformatf("random_%0d", i));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_abort();
    test_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
